lsb_queue: RTL and testbench
============================

// Module: lsb_queue
// PURPOSE
//  Parametrised load/store buffer between dispatch and memctrl; next generation of the single-CDB LSB.
//  Holds memory ops in program order in a circular queue of DEPTH entries.
//  Snoops NUM_CDB broadcast channels plus its own load results to resolve operands.
//  Issues head entry to memctrl: loads once operands ready, stores only when at ROB head. Supports flush.
// PARAMETERS
//  DEPTH    16  queue entries, power of two >= 2
//  ROB_W    4   ROB index width (`ROB_WIDTH_BIT)
//  NUM_CDB  2   external CDB channels snooped per cycle
// PORTS
//  clk_in          in   1            clock, all state on posedge
//  rst_n_in        in   1            asynchronous active-low reset
//  rdy_in          in   1            0 = hold all state, outputs frozen
//  flush_in        in   1            mispredict: drop all entries
//  lsb_full        out  1            count == DEPTH
//  task_in         in   1            enqueue at tail (ignored when full)
//  op_type         in   6            10 LB,11 LH,12 LW,13 LBU,14 LHU,20 SB,21 SH,22 SW
//  vj_in/vk_in     in   32           base / store data values
//  qj_in/qk_in     in   ROB_W        producer tags
//  j_in/k_in       in   1            1 = value valid
//  imm_in          in   32           address offset
//  rob_id_in       in   ROB_W        ROB slot of this op
//  cdb_valid       in   NUM_CDB      per-channel broadcast valid
//  cdb_rob_id      in   NUM_CDB*ROB_W  flattened tags, channel c at [c*ROB_W+:ROB_W]
//  cdb_value       in   NUM_CDB*32   flattened values
//  rob_head        in   ROB_W        oldest uncommitted ROB slot
//  mem_req         out  1            request valid, held until mem_ack
//  mem_ack         in   1            memctrl accepted request
//  mem_done        in   1            load data valid (one cycle)
//  mem_rdata       in   32           raw load data
//  l_or_s          out  1            0 load, 1 store
//  width           out  3            bytes 1/2/4
//  address         out  32           vj + imm, mod 2^32
//  value_store     out  32           vk masked to width
//  res_valid       out  1            one-cycle result to ROB/CDB
//  res_rob_id      out  ROB_W        result tag
//  res_value       out  32           extended load value, 0 for stores
// BEHAVIOUR
//  Reset: head=tail=count=0, all busy=0, state IDLE, mem_req=0, res_valid=0, other outputs 0.
//  Enqueue: task_in & !full writes tail, tail wraps DEPTH-1->0; task_in when full is dropped.
//  Snoop: each cycle every busy entry with j=0 (k=0) matching any valid CDB tag or own result tag
//   captures value, sets j (k); same-cycle enqueue also checks CDB (bypass on entry).
//  FSM IDLE: head busy, j&k, and (load, or store with rob_head==rob_id[head]) -> drive address/width/
//   l_or_s/value_store, mem_req=1, go REQ.
//  REQ: hold all request outputs stable until mem_ack; on ack pop head (count-1, head wraps);
//   load -> WAIT, store -> res_valid=1 with rob id, value 0, -> IDLE.
//  WAIT: on mem_done: res_valid=1 for one cycle, value sign-ext (LB/LH) or zero-ext (LBU/LHU); -> IDLE.
//  Latency: ready head to mem_req = 1 cycle; mem_done to res_valid = 1 cycle.
//  Simultaneous enqueue+pop: count unchanged; both pointers advance.
//  Flush: clears busy/head/tail/count next edge; enqueue ignored that cycle. In REQ with load or
//   store not yet acked: drop mem_req. Flush in WAIT -> DRAIN, discard next mem_done, no res_valid, -> IDLE.
//   Flush never cancels a store already acked.
//  Async reset mid-transaction: immediately all outputs to reset values; memctrl must also reset.
//  Unknown op_type at head: pop without memory access, no result.
// STRUCTURE
//  Shared package const.v: op codes, width decode, ROB_WIDTH_BIT, LSB_WIDTH_BIT defaults.
//  Sub-module lsb_snoop: per-entry tag compare over NUM_CDB+1 channels -> hit flag + value mux.
//  Queue storage, pointers and FSM stay in lsb_queue.
// TESTING
//  LW rob 3, base ready 0x100, imm 4 -> mem_req, address 0x104, width 4; mem_done 0xDEADBEEF -> res tag 3 value 0xDEADBEEF.
//  LB rdata 0x80, LBU rdata 0x80 -> 0xFFFFFF80 then 0x00000080.
//  SW rob 5 ready, rob_head=4 -> no mem_req; rob_head=5 -> mem_req, value_store=vk; ack -> res tag 5.
//  Load qj=7 unresolved; cdb channel 1 broadcasts tag 7 value 0x200 -> next cycle issue address 0x200+imm.
//  Fill DEPTH entries -> lsb_full=1, extra task_in dropped; pop+enqueue same cycle keeps count=DEPTH.
//  Flush while load in WAIT -> queue empty, subsequent mem_done produces no res_valid; new task issues normally.

Source files
------------

// File: rtl/lsb_queue_pkg.sv
// Shared definitions for the load/store buffer: op codes, default widths, FSM states
// and the width/extension helpers used on the issue and result paths.
package lsb_queue_pkg;

  localparam int ROB_WIDTH_BIT = 4;
  localparam int LSB_WIDTH_BIT = 4;

  localparam logic [5:0] OP_LB  = 6'd10;
  localparam logic [5:0] OP_LH  = 6'd11;
  localparam logic [5:0] OP_LW  = 6'd12;
  localparam logic [5:0] OP_LBU = 6'd13;
  localparam logic [5:0] OP_LHU = 6'd14;
  localparam logic [5:0] OP_SB  = 6'd20;
  localparam logic [5:0] OP_SH  = 6'd21;
  localparam logic [5:0] OP_SW  = 6'd22;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DRAIN} lsb_state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [2:0] op_width(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [31:0] raw);
    case (op)
      OP_LB:   return {{24{raw[7]}}, raw[7:0]};
      OP_LH:   return {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  return {24'd0, raw[7:0]};
      OP_LHU:  return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic [31:0] store_mask(input logic [5:0] op, input logic [31:0] data);
    case (op)
      OP_SB:   return {24'd0, data[7:0]};
      OP_SH:   return {16'd0, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsb_queue_if.sv
// Memory-controller request/response bus between the load/store buffer (master)
// and memctrl (slave).
interface lsb_queue_if;
  logic        mem_req;
  logic        mem_ack;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        l_or_s;
  logic [2:0]  width;
  logic [31:0] address;
  logic [31:0] value_store;

  modport master (
    output mem_req, l_or_s, width, address, value_store,
    input  mem_ack, mem_done, mem_rdata
  );

  modport slave (
    input  mem_req, l_or_s, width, address, value_store,
    output mem_ack, mem_done, mem_rdata
  );
endinterface

// File: rtl/lsb_queue_snoop.sv
// Tag comparator for one waiting operand: searches all broadcast channels for its
// producer tag and returns a hit flag plus the matching value.
module lsb_queue_snoop
  import lsb_queue_pkg::*;
#(
  parameter int ROB_W = ROB_WIDTH_BIT,
  parameter int NCH   = 3
) (
  input  logic [ROB_W-1:0]     tag,
  input  logic [NCH-1:0]       chan_valid,
  input  logic [NCH*ROB_W-1:0] chan_tag,
  input  logic [NCH*32-1:0]    chan_value,
  output logic                 hit,
  output logic [31:0]          value
);

  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int c = 0; c < NCH; c++) begin
      if (chan_valid[c] && (chan_tag[c*ROB_W +: ROB_W] == tag)) begin
        hit   = 1'b1;
        value = chan_value[c*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/lsb_queue.sv
// In-order load/store buffer: circular queue with operand snooping, head issue to
// memctrl (stores gated on ROB head) and one-cycle result broadcast.
module lsb_queue
  import lsb_queue_pkg::*;
#(
  parameter int DEPTH   = 1 << LSB_WIDTH_BIT,
  parameter int ROB_W   = ROB_WIDTH_BIT,
  parameter int NUM_CDB = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  output logic                     lsb_full,
  input  logic                     task_in,
  input  logic [5:0]               op_type,
  input  logic [31:0]              vj_in,
  input  logic [31:0]              vk_in,
  input  logic [ROB_W-1:0]         qj_in,
  input  logic [ROB_W-1:0]         qk_in,
  input  logic                     j_in,
  input  logic                     k_in,
  input  logic [31:0]              imm_in,
  input  logic [ROB_W-1:0]         rob_id_in,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id,
  input  logic [NUM_CDB*32-1:0]    cdb_value,
  input  logic [ROB_W-1:0]         rob_head,
  lsb_queue_if.master              mem,
  output logic                     res_valid,
  output logic [ROB_W-1:0]         res_rob_id,
  output logic [31:0]              res_value
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int NCH   = NUM_CDB + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [PTR_W:0]   count_reg;
  logic [DEPTH-1:0] busy_reg, j_reg, k_reg;
  logic [5:0]       op_reg  [DEPTH];
  logic [31:0]      vj_reg  [DEPTH];
  logic [31:0]      vk_reg  [DEPTH];
  logic [31:0]      imm_reg [DEPTH];
  logic [ROB_W-1:0] qj_reg  [DEPTH];
  logic [ROB_W-1:0] qk_reg  [DEPTH];
  logic [ROB_W-1:0] rob_reg [DEPTH];

  lsb_state_t  state_reg, state_next;
  logic        mem_req_reg, mem_req_next, l_or_s_reg, l_or_s_next;
  logic [2:0]  width_reg, width_next;
  logic [31:0] address_reg, address_next, value_store_reg, value_store_next;
  logic [5:0]  cur_op_reg, cur_op_next;
  logic [ROB_W-1:0] cur_rob_reg, cur_rob_next, res_rob_id_reg, res_rob_id_next;
  logic        res_valid_reg, res_valid_next, res_load_reg, res_load_next;
  logic [31:0] res_value_reg, res_value_next;
  logic        pop, enq, full;

  // Own load results are snooped as one extra channel alongside the CDBs
  logic [NCH-1:0]       chan_valid;
  logic [NCH*ROB_W-1:0] chan_tag;
  logic [NCH*32-1:0]    chan_value;
  assign chan_valid = {res_valid_reg & res_load_reg, cdb_valid};
  assign chan_tag   = {res_rob_id_reg, cdb_rob_id};
  assign chan_value = {res_value_reg, cdb_value};

  logic [DEPTH-1:0] hit_j, hit_k;
  logic [31:0]      snoop_vj [DEPTH];
  logic [31:0]      snoop_vk [DEPTH];
  logic             byp_hit_j, byp_hit_k;
  logic [31:0]      byp_vj, byp_vk;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_snoop
    lsb_queue_snoop #(.ROB_W(ROB_W), .NCH(NCH)) u_snoop_j (
      .tag(qj_reg[gi]), .chan_valid(chan_valid), .chan_tag(chan_tag),
      .chan_value(chan_value), .hit(hit_j[gi]), .value(snoop_vj[gi]));
    lsb_queue_snoop #(.ROB_W(ROB_W), .NCH(NCH)) u_snoop_k (
      .tag(qk_reg[gi]), .chan_valid(chan_valid), .chan_tag(chan_tag),
      .chan_value(chan_value), .hit(hit_k[gi]), .value(snoop_vk[gi]));
  end

  lsb_queue_snoop #(.ROB_W(ROB_W), .NCH(NCH)) u_bypass_j (
    .tag(qj_in), .chan_valid(chan_valid), .chan_tag(chan_tag),
    .chan_value(chan_value), .hit(byp_hit_j), .value(byp_vj));
  lsb_queue_snoop #(.ROB_W(ROB_W), .NCH(NCH)) u_bypass_k (
    .tag(qk_in), .chan_valid(chan_valid), .chan_tag(chan_tag),
    .chan_value(chan_value), .hit(byp_hit_k), .value(byp_vk));

  assign full = (count_reg == CNT_FULL);
  // A full queue still accepts a new op in the cycle its head pops (tail == head slot)
  assign enq  = task_in && !flush_in && (!full || pop);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      busy_reg  <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
        busy_reg  <= '0;
      end else begin
        if (pop) begin
          head_reg           <= head_reg + PTR_ONE;
          busy_reg[head_reg] <= 1'b0;
        end
        if (enq) begin
          tail_reg           <= tail_reg + PTR_ONE;
          busy_reg[tail_reg] <= 1'b1;
        end
        case ({enq, pop})
          2'b10:   count_reg <= count_reg + CNT_ONE;
          2'b01:   count_reg <= count_reg - CNT_ONE;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (!j_reg[e] && hit_j[e]) begin
          j_reg[e]  <= 1'b1;
          vj_reg[e] <= snoop_vj[e];
        end
        if (!k_reg[e] && hit_k[e]) begin
          k_reg[e]  <= 1'b1;
          vk_reg[e] <= snoop_vk[e];
        end
      end
      if (enq) begin
        op_reg[tail_reg]  <= op_type;
        imm_reg[tail_reg] <= imm_in;
        rob_reg[tail_reg] <= rob_id_in;
        qj_reg[tail_reg]  <= qj_in;
        qk_reg[tail_reg]  <= qk_in;
        j_reg[tail_reg]   <= j_in | byp_hit_j;
        k_reg[tail_reg]   <= k_in | byp_hit_k;
        vj_reg[tail_reg]  <= j_in ? vj_in : byp_vj;
        vk_reg[tail_reg]  <= k_in ? vk_in : byp_vk;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg       <= ST_IDLE;
      mem_req_reg     <= 1'b0;
      l_or_s_reg      <= 1'b0;
      width_reg       <= '0;
      address_reg     <= '0;
      value_store_reg <= '0;
      cur_op_reg      <= '0;
      cur_rob_reg     <= '0;
      res_valid_reg   <= 1'b0;
      res_load_reg    <= 1'b0;
      res_rob_id_reg  <= '0;
      res_value_reg   <= '0;
    end else if (rdy_in) begin
      state_reg       <= state_next;
      mem_req_reg     <= mem_req_next;
      l_or_s_reg      <= l_or_s_next;
      width_reg       <= width_next;
      address_reg     <= address_next;
      value_store_reg <= value_store_next;
      cur_op_reg      <= cur_op_next;
      cur_rob_reg     <= cur_rob_next;
      res_valid_reg   <= res_valid_next;
      res_load_reg    <= res_load_next;
      res_rob_id_reg  <= res_rob_id_next;
      res_value_reg   <= res_value_next;
    end
  end

  logic [5:0] h_op;
  assign h_op = op_reg[head_reg];

  always_comb begin
    state_next       = state_reg;
    mem_req_next     = mem_req_reg;
    l_or_s_next      = l_or_s_reg;
    width_next       = width_reg;
    address_next     = address_reg;
    value_store_next = value_store_reg;
    cur_op_next      = cur_op_reg;
    cur_rob_next     = cur_rob_reg;
    res_valid_next   = 1'b0;
    res_load_next    = res_load_reg;
    res_rob_id_next  = res_rob_id_reg;
    res_value_next   = res_value_reg;
    pop              = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!flush_in && busy_reg[head_reg]) begin
          if (!is_load(h_op) && !is_store(h_op)) begin
            pop = 1'b1;
          end else if (j_reg[head_reg] && k_reg[head_reg] &&
                       (is_load(h_op) || (rob_head == rob_reg[head_reg]))) begin
            mem_req_next     = 1'b1;
            l_or_s_next      = is_store(h_op);
            width_next       = op_width(h_op);
            address_next     = vj_reg[head_reg] + imm_reg[head_reg];
            value_store_next = store_mask(h_op, vk_reg[head_reg]);
            cur_op_next      = h_op;
            cur_rob_next     = rob_reg[head_reg];
            state_next       = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem.mem_ack) begin
          mem_req_next = 1'b0;
          pop          = 1'b1;
          if (l_or_s_reg) begin
            // An accepted store always completes, even across a flush
            res_valid_next  = 1'b1;
            res_load_next   = 1'b0;
            res_rob_id_next = cur_rob_reg;
            res_value_next  = '0;
            state_next      = ST_IDLE;
          end else begin
            state_next = flush_in ? ST_DRAIN : ST_WAIT;
          end
        end else if (flush_in) begin
          mem_req_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (flush_in) begin
          state_next = mem.mem_done ? ST_IDLE : ST_DRAIN;
        end else if (mem.mem_done) begin
          res_valid_next  = 1'b1;
          res_load_next   = 1'b1;
          res_rob_id_next = cur_rob_reg;
          res_value_next  = load_extend(cur_op_reg, mem.mem_rdata);
          state_next      = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (mem.mem_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign lsb_full        = full;
  assign mem.mem_req     = mem_req_reg;
  assign mem.l_or_s      = l_or_s_reg;
  assign mem.width       = width_reg;
  assign mem.address     = address_reg;
  assign mem.value_store = value_store_reg;
  assign res_valid       = res_valid_reg;
  assign res_rob_id      = res_rob_id_reg;
  assign res_value       = res_value_reg;

endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue: a scripted memctrl answers requests and every
// scenario task compares DUT outputs against hand-computed values.
module tb_lsb_queue;
  import lsb_queue_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, flush_in, task_in, j_in, k_in;
  logic [5:0]  op_type;
  logic [31:0] vj_in, vk_in, imm_in;
  logic [3:0]  qj_in, qk_in, rob_id_in, rob_head;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_value;
  logic        lsb_full, res_valid;
  logic [3:0]  res_rob_id;
  logic [31:0] res_value;
  int          n_cmp = 0;
  int          n_bad = 0;

  lsb_queue_if mem_if ();

  lsb_queue #(.DEPTH(16), .ROB_W(4), .NUM_CDB(2)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .lsb_full(lsb_full), .task_in(task_in), .op_type(op_type),
    .vj_in(vj_in), .vk_in(vk_in), .qj_in(qj_in), .qk_in(qk_in),
    .j_in(j_in), .k_in(k_in), .imm_in(imm_in), .rob_id_in(rob_id_in),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .rob_head(rob_head), .mem(mem_if.master),
    .res_valid(res_valid), .res_rob_id(res_rob_id), .res_value(res_value)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic enq(input logic [5:0] op, input logic [31:0] vj, input logic jv,
                     input logic [3:0] qj, input logic [31:0] vk, input logic [31:0] imm,
                     input logic [3:0] rob);
    task_in = 1'b1; op_type = op; vj_in = vj; j_in = jv; qj_in = qj;
    vk_in = vk; k_in = 1'b1; qk_in = 4'd0; imm_in = imm; rob_id_in = rob;
    tick();
    task_in = 1'b0;
  endtask

  // Bounded wait for a request; caller decides what a timeout means
  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mem_if.mem_req === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic ack_cycle();
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
  endtask

  task automatic done_cycle(input logic [31:0] data);
    mem_if.mem_done = 1'b1; mem_if.mem_rdata = data;
    tick();
    mem_if.mem_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    #3;
    n_cmp++;
    if ({mem_if.mem_req, res_valid, lsb_full} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b need 000", {mem_if.mem_req, res_valid, lsb_full});
    end
    n_cmp++;
    if ({mem_if.address, mem_if.value_store, res_value} !== 96'd0) begin
      n_bad++; $display("FAIL reset_data: addr %h vs %h res %h not all zero", mem_if.address, mem_if.value_store, res_value);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();
    $display("txn reset released");
  endtask

  task automatic test_lw();
    bit got;
    enq(OP_LW, 32'h100, 1'b1, 4'd0, 32'd0, 32'd4, 4'd3);
    n_cmp++;
    if (mem_if.mem_req !== 1'b0) begin n_bad++; $display("FAIL lw_latency: mem_req %b need 0", mem_if.mem_req); end
    tick();
    got = mem_if.mem_req;
    n_cmp++;
    if (!got || mem_if.address !== 32'h104 || mem_if.width !== 3'd4 || mem_if.l_or_s !== 1'b0) begin
      n_bad++; $display("FAIL lw_req: req %b addr %h width %0d ls %b need 1 00000104 4 0", got, mem_if.address, mem_if.width, mem_if.l_or_s);
    end
    tick();
    n_cmp++;
    if (mem_if.mem_req !== 1'b1 || mem_if.address !== 32'h104) begin
      n_bad++; $display("FAIL lw_hold: req %b addr %h need 1 00000104", mem_if.mem_req, mem_if.address);
    end
    ack_cycle();
    n_cmp++;
    if (mem_if.mem_req !== 1'b0 || res_valid !== 1'b0) begin
      n_bad++; $display("FAIL lw_ack: req %b res_valid %b need 0 0", mem_if.mem_req, res_valid);
    end
    done_cycle(32'hDEADBEEF);
    n_cmp++;
    if (res_valid !== 1'b1 || res_rob_id !== 4'd3 || res_value !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL lw_result: v %b tag %0d val %h need 1 3 deadbeef", res_valid, res_rob_id, res_value);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b0) begin n_bad++; $display("FAIL lw_pulse: res_valid %b need 0", res_valid); end
    $display("txn LW rob3 addr %h result %h", 32'h104, 32'hDEADBEEF);
  endtask

  task automatic test_lb_lbu();
    bit got;
    enq(OP_LB,  32'h40, 1'b1, 4'd0, 32'd0, 32'd1, 4'd1);
    enq(OP_LBU, 32'h40, 1'b1, 4'd0, 32'd0, 32'd2, 4'd2);
    wait_req(got);
    n_cmp++;
    if (!got || mem_if.address !== 32'h41 || mem_if.width !== 3'd1) begin
      n_bad++; $display("FAIL lb_req: req %b addr %h width %0d need 1 00000041 1", got, mem_if.address, mem_if.width);
    end
    ack_cycle();
    done_cycle(32'h00000080);
    n_cmp++;
    if (res_valid !== 1'b1 || res_rob_id !== 4'd1 || res_value !== 32'hFFFFFF80) begin
      n_bad++; $display("FAIL lb_sext: v %b tag %0d val %h need 1 1 ffffff80", res_valid, res_rob_id, res_value);
    end
    $display("txn LB rob1 result %h", res_value);
    wait_req(got);
    n_cmp++;
    if (!got || mem_if.address !== 32'h42 || mem_if.width !== 3'd1) begin
      n_bad++; $display("FAIL lbu_req: req %b addr %h width %0d need 1 00000042 1", got, mem_if.address, mem_if.width);
    end
    ack_cycle();
    done_cycle(32'h00000080);
    n_cmp++;
    if (res_valid !== 1'b1 || res_rob_id !== 4'd2 || res_value !== 32'h00000080) begin
      n_bad++; $display("FAIL lbu_zext: v %b tag %0d val %h need 1 2 00000080", res_valid, res_rob_id, res_value);
    end
    $display("txn LBU rob2 result %h", res_value);
  endtask

  task automatic test_store();
    bit got;
    rob_head = 4'd4;
    enq(OP_SW, 32'h300, 1'b1, 4'd0, 32'hCAFEF00D, 32'd8, 4'd5);
    repeat (3) tick();
    n_cmp++;
    if (mem_if.mem_req !== 1'b0) begin n_bad++; $display("FAIL sw_gate: mem_req %b need 0", mem_if.mem_req); end
    rob_head = 4'd5;
    wait_req(got);
    n_cmp++;
    if (!got || mem_if.l_or_s !== 1'b1 || mem_if.address !== 32'h308 ||
        mem_if.width !== 3'd4 || mem_if.value_store !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL sw_req: req %b ls %b addr %h w %0d data %h need 1 1 00000308 4 cafef00d",
                        got, mem_if.l_or_s, mem_if.address, mem_if.width, mem_if.value_store);
    end
    ack_cycle();
    n_cmp++;
    if (res_valid !== 1'b1 || res_rob_id !== 4'd5 || res_value !== 32'd0 || mem_if.mem_req !== 1'b0) begin
      n_bad++; $display("FAIL sw_result: v %b tag %0d val %h req %b need 1 5 0 0", res_valid, res_rob_id, res_value, mem_if.mem_req);
    end
    $display("txn SW rob5 addr %h", 32'h308);
    rob_head = 4'd6;
    enq(OP_SB, 32'h40, 1'b1, 4'd0, 32'h12345678, 32'd3, 4'd6);
    wait_req(got);
    n_cmp++;
    if (!got || mem_if.value_store !== 32'h78 || mem_if.width !== 3'd1 || mem_if.address !== 32'h43) begin
      n_bad++; $display("FAIL sb_req: req %b data %h w %0d addr %h need 1 00000078 1 00000043",
                        got, mem_if.value_store, mem_if.width, mem_if.address);
    end
    ack_cycle();
    n_cmp++;
    if (res_valid !== 1'b1 || res_rob_id !== 4'd6) begin
      n_bad++; $display("FAIL sb_result: v %b tag %0d need 1 6", res_valid, res_rob_id);
    end
    $display("txn SB rob6 data %h", 32'h78);
  endtask

  task automatic test_snoop();
    bit got;
    enq(OP_LW, 32'd0, 1'b0, 4'd7, 32'd0, 32'h10, 4'd8);
    repeat (2) tick();
    n_cmp++;
    if (mem_if.mem_req !== 1'b0) begin n_bad++; $display("FAIL cdb_wait: mem_req %b need 0", mem_if.mem_req); end
    cdb_valid = 2'b10; cdb_rob_id = {4'd7, 4'd0}; cdb_value = {32'h200, 32'h0};
    tick();
    cdb_valid = 2'b00;
    wait_req(got);
    n_cmp++;
    if (!got || mem_if.address !== 32'h210) begin
      n_bad++; $display("FAIL cdb_issue: req %b addr %h need 1 00000210", got, mem_if.address);
    end
    ack_cycle();
    done_cycle(32'h11);
    $display("txn LW rob8 via cdb1 addr %h", 32'h210);
    // Tag broadcast in the very cycle the op is enqueued
    cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd9}; cdb_value = {32'h0, 32'h700};
    enq(OP_LW, 32'd0, 1'b0, 4'd9, 32'd0, 32'd4, 4'd10);
    cdb_valid = 2'b00;
    wait_req(got);
    n_cmp++;
    if (!got || mem_if.address !== 32'h704) begin
      n_bad++; $display("FAIL cdb_bypass: req %b addr %h need 1 00000704", got, mem_if.address);
    end
    ack_cycle();
    done_cycle(32'h22);
    $display("txn LW rob10 bypass addr %h", 32'h704);
    enq(OP_LW, 32'h500, 1'b1, 4'd0, 32'd0, 32'd0, 4'd1);
    enq(OP_LW, 32'd0, 1'b0, 4'd1, 32'd0, 32'd8, 4'd2);
    wait_req(got);
    ack_cycle();
    done_cycle(32'h600);
    wait_req(got);
    n_cmp++;
    if (!got || mem_if.address !== 32'h608) begin
      n_bad++; $display("FAIL own_forward: req %b addr %h need 1 00000608", got, mem_if.address);
    end
    ack_cycle();
    done_cycle(32'h33);
    n_cmp++;
    if (res_valid !== 1'b1 || res_rob_id !== 4'd2 || res_value !== 32'h33) begin
      n_bad++; $display("FAIL own_result: v %b tag %0d val %h need 1 2 00000033", res_valid, res_rob_id, res_value);
    end
    $display("txn LW rob2 forwarded addr %h", 32'h608);
  endtask

  task automatic test_full();
    bit got;
    for (int i = 0; i < 16; i++) begin
      enq(OP_LW, 32'd0, 1'b0, 4'd9, 32'd0, 32'(i*4), 4'(i));
      if (i == 14) begin
        n_cmp++;
        if (lsb_full !== 1'b0) begin n_bad++; $display("FAIL full_15: lsb_full %b need 0", lsb_full); end
      end
    end
    n_cmp++;
    if (lsb_full !== 1'b1) begin n_bad++; $display("FAIL full_16: lsb_full %b need 1", lsb_full); end
    enq(OP_LW, 32'd0, 1'b1, 4'd0, 32'd0, 32'h999, 4'd0);
    n_cmp++;
    if (lsb_full !== 1'b1 || mem_if.mem_req !== 1'b0) begin
      n_bad++; $display("FAIL full_drop: full %b req %b need 1 0", lsb_full, mem_if.mem_req);
    end
    cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd9}; cdb_value = {32'h0, 32'h2000};
    tick();
    cdb_valid = 2'b00;
    wait_req(got);
    n_cmp++;
    if (!got || mem_if.address !== 32'h2000) begin
      n_bad++; $display("FAIL full_first: req %b addr %h need 1 00002000", got, mem_if.address);
    end
    // Pop and enqueue in the same cycle while full
    mem_if.mem_ack = 1'b1;
    task_in = 1'b1; op_type = OP_LW; vj_in = 32'h3000; j_in = 1'b1; k_in = 1'b1;
    imm_in = 32'd0; rob_id_in = 4'd15;
    tick();
    mem_if.mem_ack = 1'b0; task_in = 1'b0;
    n_cmp++;
    if (lsb_full !== 1'b1) begin n_bad++; $display("FAIL full_popenq: lsb_full %b need 1", lsb_full); end
    done_cycle(32'hA0);
    for (int i = 1; i < 17; i++) begin
      wait_req(got);
      n_cmp++;
      if (!got || mem_if.address !== ((i == 16) ? 32'h3000 : 32'h2000 + 32'(i*4))) begin
        n_bad++; $display("FAIL full_order%0d: req %b addr %h need 1 %h", i, got, mem_if.address,
                          (i == 16) ? 32'h3000 : 32'h2000 + 32'(i*4));
      end
      ack_cycle();
      done_cycle(32'(i));
      n_cmp++;
      if (res_valid !== 1'b1 || res_rob_id !== ((i == 16) ? 4'd15 : 4'(i)) || res_value !== 32'(i)) begin
        n_bad++; $display("FAIL full_res%0d: v %b tag %0d val %h need 1 %0d %h", i, res_valid, res_rob_id,
                          res_value, (i == 16) ? 15 : i, 32'(i));
      end
      $display("txn drain %0d addr %h", i, mem_if.address);
    end
    repeat (4) tick();
    n_cmp++;
    if (lsb_full !== 1'b0 || mem_if.mem_req !== 1'b0) begin
      n_bad++; $display("FAIL full_empty: full %b req %b need 0 0", lsb_full, mem_if.mem_req);
    end
  endtask

  task automatic test_flush();
    bit got;
    bit saw;
    enq(OP_LW, 32'h800, 1'b1, 4'd0, 32'd0, 32'd0, 4'd4);
    wait_req(got);
    ack_cycle();
    enq(OP_LW, 32'h880, 1'b1, 4'd0, 32'd0, 32'd0, 4'd6);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    done_cycle(32'h55);
    saw = res_valid;
    tick();
    saw = saw | res_valid;
    n_cmp++;
    if (saw !== 1'b0) begin n_bad++; $display("FAIL flush_drain: res_valid seen %b need 0", saw); end
    saw = 1'b0;
    repeat (3) begin
      tick();
      saw = saw | mem_if.mem_req;
    end
    n_cmp++;
    if (saw !== 1'b0 || lsb_full !== 1'b0) begin
      n_bad++; $display("FAIL flush_empty: req seen %b full %b need 0 0", saw, lsb_full);
    end
    enq(OP_LW, 32'h900, 1'b1, 4'd0, 32'd0, 32'd0, 4'd2);
    wait_req(got);
    n_cmp++;
    if (!got || mem_if.address !== 32'h900) begin
      n_bad++; $display("FAIL flush_after: req %b addr %h need 1 00000900", got, mem_if.address);
    end
    ack_cycle();
    done_cycle(32'h77);
    n_cmp++;
    if (res_valid !== 1'b1 || res_rob_id !== 4'd2 || res_value !== 32'h77) begin
      n_bad++; $display("FAIL flush_result: v %b tag %0d val %h need 1 2 00000077", res_valid, res_rob_id, res_value);
    end
    $display("txn flush in WAIT, then LW rob2 addr %h", 32'h900);
    enq(OP_LW, 32'h950, 1'b1, 4'd0, 32'd0, 32'd0, 4'd3);
    wait_req(got);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    saw = mem_if.mem_req;
    repeat (3) begin
      tick();
      saw = saw | mem_if.mem_req;
    end
    n_cmp++;
    if (saw !== 1'b0) begin n_bad++; $display("FAIL flush_req: mem_req seen %b need 0", saw); end
    $display("txn flush in REQ");
  endtask

  task automatic test_misc();
    bit got;
    bit saw;
    rdy_in = 1'b0;
    enq(OP_LW, 32'hB00, 1'b1, 4'd0, 32'd0, 32'd0, 4'd7);
    tick();
    rdy_in = 1'b1;
    saw = 1'b0;
    repeat (3) begin
      tick();
      saw = saw | mem_if.mem_req;
    end
    n_cmp++;
    if (saw !== 1'b0) begin n_bad++; $display("FAIL rdy_hold: mem_req seen %b need 0", saw); end
    enq(6'd5, 32'h0, 1'b1, 4'd0, 32'd0, 32'd0, 4'd3);
    enq(OP_LW, 32'hA00, 1'b1, 4'd0, 32'd0, 32'd0, 4'd4);
    wait_req(got);
    n_cmp++;
    if (!got || mem_if.address !== 32'hA00) begin
      n_bad++; $display("FAIL unknown_op: req %b addr %h need 1 00000a00", got, mem_if.address);
    end
    ack_cycle();
    done_cycle(32'h44);
    n_cmp++;
    if (res_valid !== 1'b1 || res_rob_id !== 4'd4) begin
      n_bad++; $display("FAIL unknown_res: v %b tag %0d need 1 4", res_valid, res_rob_id);
    end
    $display("txn unknown op skipped, LW rob4 addr %h", 32'hA00);
  endtask

  task automatic test_async_reset();
    bit got;
    bit saw;
    enq(OP_LW, 32'hC00, 1'b1, 4'd0, 32'd0, 32'd0, 4'd9);
    wait_req(got);
    #2;
    rst_n_in = 1'b0;
    #1;
    n_cmp++;
    if (mem_if.mem_req !== 1'b0 || mem_if.address !== 32'd0 || mem_if.width !== 3'd0) begin
      n_bad++; $display("FAIL async_rst: req %b addr %h w %0d need 0 0 0", mem_if.mem_req, mem_if.address, mem_if.width);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      tick();
      saw = saw | mem_if.mem_req;
    end
    n_cmp++;
    if (saw !== 1'b0) begin n_bad++; $display("FAIL async_clear: mem_req seen %b need 0", saw); end
    $display("txn async reset during REQ");
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; task_in = 1'b0;
    op_type = 6'd0; vj_in = '0; vk_in = '0; qj_in = '0; qk_in = '0; j_in = 1'b0; k_in = 1'b0;
    imm_in = '0; rob_id_in = '0; rob_head = '0;
    cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0;
    mem_if.mem_ack = 1'b0; mem_if.mem_done = 1'b0; mem_if.mem_rdata = '0;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_store();
    test_snoop();
    test_full();
    test_flush();
    test_misc();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
